// File: rtl/itof_converter.sv
// Integer (signed/unsigned 32-bit) to IEEE 754 binary32 converter with valid/ready handshake.
// Define ITOF_OUT_REG_EN to register the rounded result in a second stage (latency 2).
module itof_converter (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        valid_out,
    input  logic        ready_in,
    input  logic [4:0]  op,
    input  logic [2:0]  rm,
    input  logic [31:0] int_in,
    output logic [31:0] float_out,
    output logic        IE
);

    localparam logic [4:0] FPU_OP_CVTIF = 5'd9;
    localparam logic [4:0] FPU_OP_CVTUF = 5'd10;

    localparam logic [2:0] FPU_RM_RNE = 3'd0;
    localparam logic [2:0] FPU_RM_RTZ = 3'd1;
    localparam logic [2:0] FPU_RM_RDN = 3'd2;
    localparam logic [2:0] FPU_RM_RUP = 3'd3;
    localparam logic [2:0] FPU_RM_RMM = 3'd4;

    logic        s1_valid_q, s1_valid_d;
    logic [2:0]  rm_q, rm_d;
    logic        sgn_q, sgn_d;
    logic [7:0]  exp_q, exp_d;
    logic [22:0] man_q, man_d;
    logic        rnd_q, rnd_d;
    logic        stk_q, stk_d;
    logic        zero_q, zero_d;

    logic        accept;
    logic        s1_xfer;
    logic        in_sgn;
    logic [31:0] in_mag;
    logic [4:0]  in_lz;
    logic [31:0] in_norm;

    logic        inc;
    logic [23:0] man_rnd;
    logic [31:0] rnd_float;
    logic        rnd_ie;

    // Normalise the magnitude so its leading one sits at bit 31
    always_comb begin
        in_sgn = (op == FPU_OP_CVTIF) && int_in[31];
        in_mag = in_sgn ? (~int_in + 32'd1) : int_in;
        in_lz  = '0;
        for (int i = 0; i < 32; i++) begin
            if (in_mag[i]) in_lz = 5'(31 - i);
        end
        in_norm = in_mag << in_lz;
    end

    assign accept = valid_in && ready_out && ((op == FPU_OP_CVTIF) || (op == FPU_OP_CVTUF));

    always_comb begin
        s1_valid_d = s1_valid_q;
        rm_d       = rm_q;
        sgn_d      = sgn_q;
        exp_d      = exp_q;
        man_d      = man_q;
        rnd_d      = rnd_q;
        stk_d      = stk_q;
        zero_d     = zero_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            rm_d       = rm;
            sgn_d      = in_sgn;
            exp_d      = 8'd158 - {3'b000, in_lz};
            man_d      = in_norm[30:8];
            rnd_d      = in_norm[7];
            stk_d      = |in_norm[6:0];
            zero_d     = (in_mag == 32'd0);
        end else if (s1_xfer) begin
            s1_valid_d = 1'b0;
            rm_d       = '0;
            sgn_d      = 1'b0;
            exp_d      = '0;
            man_d      = '0;
            rnd_d      = 1'b0;
            stk_d      = 1'b0;
            zero_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            rm_q       <= '0;
            sgn_q      <= 1'b0;
            exp_q      <= '0;
            man_q      <= '0;
            rnd_q      <= 1'b0;
            stk_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            rm_q       <= rm_d;
            sgn_q      <= sgn_d;
            exp_q      <= exp_d;
            man_q      <= man_d;
            rnd_q      <= rnd_d;
            stk_q      <= stk_d;
            zero_q     <= zero_d;
        end
    end

    always_comb begin
        inc = 1'b0;
        case (rm_q)
            FPU_RM_RNE: inc = rnd_q && (stk_q || man_q[0]);
            FPU_RM_RTZ: inc = 1'b0;
            FPU_RM_RDN: inc = sgn_q && (rnd_q || stk_q);
            FPU_RM_RUP: inc = !sgn_q && (rnd_q || stk_q);
            FPU_RM_RMM: inc = rnd_q;
            default:    inc = rnd_q && (stk_q || man_q[0]);
        endcase
        // Carry-out leaves the low 23 bits zero and bumps the exponent
        man_rnd   = {1'b0, man_q} + {23'd0, inc};
        rnd_float = {sgn_q, exp_q + {7'd0, man_rnd[23]}, man_rnd[22:0]};
        rnd_ie    = rnd_q || stk_q;
        if (zero_q) begin
            rnd_float = '0;
            rnd_ie    = 1'b0;
        end
    end

`ifdef ITOF_OUT_REG_EN
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] float_q, float_d;
    logic        ie_q, ie_d;
    logic        s2_load;

    assign s2_load   = !s2_valid_q || ready_in;
    assign s1_xfer   = s1_valid_q && s2_load;
    assign ready_out = !s1_valid_q || s2_load;

    always_comb begin
        s2_valid_d = s2_valid_q;
        float_d    = float_q;
        ie_d       = ie_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            float_d    = s1_valid_q ? rnd_float : 32'd0;
            ie_d       = s1_valid_q && rnd_ie;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            float_q    <= '0;
            ie_q       <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            float_q    <= float_d;
            ie_q       <= ie_d;
        end
    end

    assign valid_out = s2_valid_q;
    assign float_out = float_q;
    assign IE        = ie_q;
`else
    assign s1_xfer   = s1_valid_q && ready_in;
    assign ready_out = ready_in || !s1_valid_q;
    assign valid_out = s1_valid_q;
    assign float_out = rnd_float;
    assign IE        = rnd_ie;
`endif

endmodule

// File: tb/tb_itof_converter.sv
// Self-checking bench for itof_converter: scoreboard against an arithmetic reference model.
module tb_itof_converter;

    localparam logic [4:0] OP_CVTFI = 5'd8;
    localparam logic [4:0] OP_CVTIF = 5'd9;
    localparam logic [4:0] OP_CVTUF = 5'd10;
    localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;
`ifdef ITOF_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic [4:0]  op = '0;
    logic [2:0]  rm = '0;
    logic [31:0] int_in = '0;
    logic [31:0] float_out;
    logic        IE;

    int checks = 0;
    int failures = 0;
    int n_out = 0;
    logic [32:0] exp_q[$];

    itof_converter dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .op        (op),
        .rm        (rm),
        .int_in    (int_in),
        .float_out (float_out),
        .IE        (IE)
    );

    always #5 clk = ~clk;

    // Reference: exact integer division into quotient and remainder, then round on the remainder
    function automatic logic [32:0] model(input logic [4:0] o, input logic [2:0] r,
                                          input logic [31:0] v);
        logic s;
        longint unsigned mag, q, rem, half;
        int p, sh;
        bit inc;
        logic [7:0] e;
        s = (o == OP_CVTIF) && v[31];
        mag = s ? (64'd4294967296 - {32'd0, v}) : {32'd0, v};
        if (mag == 0) return 33'd0;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        rem = 0;
        half = 0;
        if (p <= 23) begin
            q = mag << (23 - p);
        end else begin
            sh = p - 23;
            q = mag >> sh;
            rem = mag - (q << sh);
            half = 64'd1 << (sh - 1);
        end
        case (r)
            RTZ:     inc = 1'b0;
            RDN:     inc = s && (rem != 0);
            RUP:     inc = !s && (rem != 0);
            RMM:     inc = (rem != 0) && (rem >= half);
            default: inc = (rem > half) || ((rem != 0) && (rem == half) && q[0]);
        endcase
        q = q + {63'd0, inc};
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            p++;
        end
        e = 8'(127 + p);
        return {rem != 0, s, e, q[22:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard and protocol monitor, sampling on the falling edge
    logic        hold_pend = 1'b0;
    logic [31:0] held_f;
    logic        held_ie;
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                checks++;
                if (!valid_out || float_out !== held_f || IE !== held_ie) begin
                    failures++;
                    $display("FAIL hold_stable actual=%b/%h/%b required=1/%h/%b",
                             valid_out, float_out, IE, held_f, held_ie);
                end
            end
            hold_pend = valid_out && !ready_in;
            held_f = float_out;
            held_ie = IE;
`ifdef ITOF_OUT_REG_EN
            if (ready_in || !valid_out) begin
                checks++;
                if (ready_out !== 1'b1) begin
                    failures++;
                    $display("FAIL ready_out actual=%b required=1", ready_out);
                end
            end
`else
            checks++;
            if (ready_out !== (ready_in || !valid_out)) begin
                failures++;
                $display("FAIL ready_out actual=%b required=%b", ready_out, ready_in || !valid_out);
            end
`endif
            if (valid_out && ready_in) begin
                n_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_out actual=%h required=none", float_out);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    if ({IE, float_out} !== e) begin
                        failures++;
                        $display("FAIL result actual=%b/%h required=%b/%h",
                                 IE, float_out, e[32], e[31:0]);
                    end
                end
            end
            if (valid_in && ready_out && (op == OP_CVTIF || op == OP_CVTUF))
                exp_q.push_back(model(op, rm, int_in));
        end
    end

    task automatic run_one(input string name, input logic [4:0] o, input logic [2:0] r,
                           input logic [31:0] v, input logic [31:0] ef, input logic eie);
        int k;
        bit got;
        chk({name, "_model"}, {31'd0, model(o, r, v)}, {31'd0, eie, ef});
        @(posedge clk); #1;
        valid_in = 1'b1; op = o; rm = r; int_in = v; ready_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        got = 0;
        k = 0;
        while (!got && k < 6) begin
            @(negedge clk);
            k++;
            if (valid_out) got = 1;
        end
        chk({name, "_latency"}, 64'(k), 64'(LAT));
        chk({name, "_float"}, {32'd0, float_out}, {32'd0, ef});
        chk({name, "_ie"}, {63'd0, IE}, {63'd0, eie});
    endtask

    typedef struct {
        logic [4:0]  o;
        logic [2:0]  r;
        logic [31:0] v;
        logic [31:0] f;
        logic        ie;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int cnt;
        vecs = '{
            '{OP_CVTIF, RNE, 32'h00000001, 32'h3F800000, 1'b0},
            '{OP_CVTIF, RNE, 32'hFFFFFFFD, 32'hC0400000, 1'b0},
            '{OP_CVTIF, RNE, 32'h00000000, 32'h00000000, 1'b0},
            '{OP_CVTIF, RDN, 32'h00000000, 32'h00000000, 1'b0},
            '{OP_CVTIF, RUP, 32'h80000000, 32'hCF000000, 1'b0},
            '{OP_CVTIF, RDN, 32'h80000000, 32'hCF000000, 1'b0},
            '{OP_CVTUF, RNE, 32'h80000000, 32'h4F000000, 1'b0},
            '{OP_CVTUF, RNE, 32'hFFFFFFFF, 32'h4F800000, 1'b1},
            '{OP_CVTUF, RTZ, 32'hFFFFFFFF, 32'h4F7FFFFF, 1'b1},
            '{OP_CVTUF, RDN, 32'hFFFFFFFF, 32'h4F7FFFFF, 1'b1},
            '{OP_CVTIF, RNE, 32'h01000001, 32'h4B800000, 1'b1},
            '{OP_CVTIF, RUP, 32'h01000001, 32'h4B800001, 1'b1},
            '{OP_CVTIF, RMM, 32'h01000001, 32'h4B800001, 1'b1},
            '{OP_CVTIF, 3'd7, 32'h01000001, 32'h4B800000, 1'b1},
            '{OP_CVTIF, RDN, 32'hFEFFFFFF, 32'hCB800001, 1'b1},
            '{OP_CVTIF, RUP, 32'hFEFFFFFF, 32'hCB800000, 1'b1}
        };

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid_out", {63'd0, valid_out}, 64'd0);
        chk("reset_float_out", {32'd0, float_out}, 64'd0);
        chk("reset_ie", {63'd0, IE}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_one($sformatf("vec%0d", i), vecs[i].o, vecs[i].r, vecs[i].v, vecs[i].f, vecs[i].ie);
        end

        // Stall: keep offering operands until both buffers fill, then hold for 5 cycles
        @(posedge clk); #1;
        ready_in = 1'b0; valid_in = 1'b1; op = OP_CVTUF; rm = RNE; int_in = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        #1 valid_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ready_out", {63'd0, ready_out}, 64'd0);
            chk("stall_float", {32'd0, float_out}, {32'd0, 32'h4F800000});
            chk("stall_ie", {63'd0, IE}, 64'd1);
        end
        @(posedge clk); #1;
        ready_in = 1'b1;
        repeat (4) @(posedge clk);

        // Non-conversion op is ignored
        #1 valid_in = 1'b1; op = OP_CVTFI; int_in = 32'd7;
        @(posedge clk); #1;
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ignored_op", {63'd0, valid_out}, 64'd0);
        end

        // Back-to-back stream: expect one result per cycle
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            valid_in = 1'b1; op = (i % 2) ? OP_CVTUF : OP_CVTIF; rm = 3'(i % 5);
            int_in = $urandom;
            @(negedge clk);
            if (valid_out) cnt++;
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            if (valid_out) cnt++;
            if (i < LAT - 1) @(posedge clk);
        end
        chk("b2b_throughput", 64'(cnt), 64'd8);
        repeat (3) @(posedge clk);

        // Reset while a result is pending
        #1 valid_in = 1'b1; op = OP_CVTIF; rm = RNE; int_in = 32'd5; ready_in = 1'b0;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid_out", {63'd0, valid_out}, 64'd0);
        chk("rst_float_out", {32'd0, float_out}, 64'd0);
        chk("rst_ie", {63'd0, IE}, 64'd0);

        // Randomised traffic with random back-pressure
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] sel;
            @(posedge clk); #1;
            reset = ($urandom % 700) == 0;
            valid_in = ($urandom % 4) != 0;
            sel = $urandom % 8;
            op = (sel < 3) ? OP_CVTIF : (sel < 6) ? OP_CVTUF : (sel == 6) ? OP_CVTFI : 5'($urandom);
            rm = 3'($urandom);
            sel = $urandom % 6;
            case (sel)
                0: int_in = $urandom % 16 - 8;
                1: int_in = (32'd1 << ($urandom % 32)) + ($urandom % 3) - 1;
                2: int_in = ($urandom % 2) ? 32'h80000000 : 32'hFFFFFFFF;
                3: int_in = $urandom >> ($urandom % 32);
                4: int_in = ($urandom % 2) ? 32'h7FFFFFFF : 32'h01000001;
                default: int_in = $urandom;
            endcase
            ready_in = ($urandom % 3) != 0;
        end
        @(posedge clk); #1;
        reset = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("outputs_seen", 64'(n_out > 500), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
